cfg_frame_loader: RTL
=====================

// Module: cfg_frame_loader
// PURPOSE
//  Serial configuration loader feeding the FSM_LAT jump table and the clock/output selectors.
//  - Hunts the REG_STATE bit stream for a 5-bit preamble, then captures a 27-bit payload.
//  - Payload: out_sel, clk_sel, five 5-bit jump states.
//  - Publishes the payload atomically and raises finished, which releases the FSM.
//  - A framed, validated load replaces an unframed shift register, so line noise cannot corrupt the table.
// PARAMETERS
//  STATE_W   5         width of one jump-state field
//  N_STATES  5         number of jump-state fields
//  PRE_W     5         preamble width
//  PREAMBLE  5'b01010  sync pattern, MSB first
// PORTS
//  clk       in   1  single clock (rising edge); all logic is in this domain
//  rst       in   1  synchronous reset, active-high
//  in        in   1  serial config bit, sampled when en=1
//  en        in   1  bit-valid strobe; en=0 freezes all state, counters and outputs
//  clk_sel   out  1  captured clock-select bit (0 = clk_in)
//  out_sel   out  1  captured output-mux select bit
//  out1..5   out  5  captured jump states 1..5
//  finished  out  1  high once any valid frame has loaded; sticky until rst
//  load_pulse out 1  one-cycle pulse on every successful load
//  frame_err out  1  one-cycle pulse on a rejected frame
//  busy      out  1  high in LOAD/CHECK
// BEHAVIOUR
//  Reset: all outputs 0, FSM=HUNT, window/fill/bit counters cleared.
//  Bit order: MSB first, all fields.
//   - Payload bit 0 is out_sel, bit 1 is clk_sel.
//   - Then out1[4] .. out1[0], out2[4] .. out2[0], and so on through out5[0].
//   - FRAME_W = 2 + N_STATES*STATE_W = 27.
//  HUNT: on each en=1, shift in into a 5-bit window and increment the saturating fill count (0..5).
//   - Match condition: fill==5 && window==PREAMBLE. The match includes the bit sampled this cycle.
//   - On match, go to LOAD with the bit counter at 0.
//   - On entry to HUNT, window and fill are cleared, so a stale prefix never matches.
//  LOAD: each en=1 bit goes into the 27-bit shadow register and increments the bit counter.
//   - A preamble pattern inside the payload is ignored.
//   - After bit 26: go to CHECK (or to PARITY when CFG_PARITY_EN is defined).
//  PARITY (macro only): the next en=1 bit is an even-parity bit over the 27 payload bits, then go to CHECK.
//  CHECK: lasts exactly one cycle, independent of en.
//   - Valid frame: copy shadow to the outputs, load_pulse=1, finished=1, go to HUNT.
//   - Invalid frame: outputs unchanged, frame_err=1, go to HUNT.
//  Latency: the last frame bit is sampled at edge k; outputs update and load_pulse asserts at edge k+1.
//  Outputs are registered and change only in CHECK, never partially.
//  Back-to-back frames: the next preamble is accepted from the cycle after CHECK.
//  rst mid-frame: shadow discarded, outputs cleared, finished=0.
//  en=0 mid-frame: the frame pauses indefinitely; there is no timeout.
// CONFIGURATION
//  CFG_PARITY_EN defined:
//   - Frame is PRE_W + 27 + 1 bits.
//   - A parity mismatch causes frame_err and no load.
//  CFG_PARITY_EN undefined:
//   - No parity bit; every completed frame is valid.
//   - frame_err is tied to 0.
// STRUCTURE
//  Shared header fsm_lat_defs.vh holds:
//   - STATE_W, N_STATES, PRE_W, PREAMBLE, FRAME_W.
//   - FSM encodings: HUNT=2'd0, LOAD=2'd1, PARITY=2'd2, CHECK=2'd3.
//  One sub-module, cfg_shift_reg: parameterised width, en-gated MSB-first shift.
//   - Used for both the preamble window and the payload shadow.
// TESTING
//  1. rst high for 2 clks, then idle -> all outputs 0, finished=0, busy=0.
//  2. Stream 01010 + 1,0 + 00001,00010,00011,00100,00101 ->
//     one cycle after the last bit: out_sel=1, clk_sel=0, out1..5=1..5, load_pulse=1, finished=1.
//  3. Noise 0101 then 1 (first fill) -> match only after 5 bits sampled since HUNT entry;
//     stream 0001010 -> match on the final 0.
//  4. Toggle en every other cycle during case 2 -> identical result; latency counts only en=1 bits.
//  5. Assert rst at payload bit 13 -> outputs 0 and finished=0.
//     A fresh full frame then loads correctly.
//  6. CFG_PARITY_EN defined, wrong parity bit -> frame_err pulse, previous config held, finished unchanged.
//     Correct parity -> load_pulse.

Source files
------------

// File: rtl/cfg_frame_loader_pkg.sv
// Shared constants, FSM encoding and field helper for the configuration frame loader.
package cfg_frame_loader_pkg;

  localparam int unsigned STATE_W  = 5;
  localparam int unsigned N_STATES = 5;
  localparam int unsigned PRE_W    = 5;
  localparam logic [PRE_W-1:0] PREAMBLE = 5'b01010;
  localparam int unsigned FRAME_W  = 2 + N_STATES * STATE_W;
  localparam int unsigned CNT_W    = $clog2(FRAME_W);
  localparam int unsigned FILL_W   = $clog2(PRE_W + 1);

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StLoad   = 2'd1,
    StParity = 2'd2,
    StCheck  = 2'd3
  } state_e;

  // Jump state idx (0-based) sits below out_sel/clk_sel, first field most significant.
  function automatic logic [STATE_W-1:0] jump_field(input logic [FRAME_W-1:0] frame,
                                                    input int unsigned idx);
    return frame[(N_STATES - 1 - idx) * STATE_W +: STATE_W];
  endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// En-gated MSB-first shift register with synchronous reset and clear.
module cfg_shift_reg #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[WIDTH-2:0], in};
    end
  end

endmodule

// File: rtl/cfg_frame_loader.sv
// Framed serial configuration loader: preamble hunt, payload capture, atomic publish.
// Optional even-parity check over the payload when CFG_PARITY_EN is defined.
module cfg_frame_loader
  import cfg_frame_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               en,
  output logic               clk_sel,
  output logic               out_sel,
  output logic [STATE_W-1:0] out1,
  output logic [STATE_W-1:0] out2,
  output logic [STATE_W-1:0] out3,
  output logic [STATE_W-1:0] out4,
  output logic [STATE_W-1:0] out5,
  output logic               finished,
  output logic               load_pulse,
  output logic               frame_err,
  output logic               busy
);

  localparam logic [CNT_W-1:0]  LastBit = CNT_W'(FRAME_W - 1);
  localparam logic [FILL_W-1:0] FillMax = FILL_W'(PRE_W);

  state_e             state_q;
  logic [FILL_W-1:0]  fill_q;
  logic [FILL_W-1:0]  fill_inc;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [PRE_W-1:0]   window_q;
  logic [PRE_W-1:0]   window_next;
  logic [FRAME_W-1:0] shadow_q;
  logic               hunt_shift;
  logic               load_shift;
  logic               match;
  logic               window_clr;
  logic               frame_ok;

  always_comb begin
    hunt_shift  = en && (state_q == StHunt);
    load_shift  = en && (state_q == StLoad);
    window_next = {window_q[PRE_W-2:0], in};
    fill_inc    = (fill_q == FillMax) ? fill_q : fill_q + 1'b1;
    // The match looks at the window including the bit sampled this cycle.
    match       = hunt_shift && (fill_inc == FillMax) && (window_next == PREAMBLE);
    // Clearing on CHECK means a fresh hunt never sees a stale prefix.
    window_clr  = match || (state_q == StCheck);
  end

  cfg_shift_reg #(
    .WIDTH(PRE_W)
  ) u_window (
    .clk(clk),
    .rst(rst),
    .clr(window_clr),
    .en (hunt_shift),
    .in (in),
    .q  (window_q)
  );

  cfg_shift_reg #(
    .WIDTH(FRAME_W)
  ) u_shadow (
    .clk(clk),
    .rst(rst),
    .clr(1'b0),
    .en (load_shift),
    .in (in),
    .q  (shadow_q)
  );

`ifdef CFG_PARITY_EN
  logic parity_ok_q;
  logic frame_err_q;
  assign frame_ok  = parity_ok_q;
  assign frame_err = frame_err_q;
`else
  assign frame_ok  = 1'b1;
  assign frame_err = 1'b0;
`endif

  assign busy = (state_q != StHunt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StHunt;
      fill_q     <= '0;
      bit_cnt_q  <= '0;
      out_sel    <= 1'b0;
      clk_sel    <= 1'b0;
      out1       <= '0;
      out2       <= '0;
      out3       <= '0;
      out4       <= '0;
      out5       <= '0;
      finished   <= 1'b0;
      load_pulse <= 1'b0;
`ifdef CFG_PARITY_EN
      parity_ok_q <= 1'b0;
      frame_err_q <= 1'b0;
`endif
    end else begin
      load_pulse <= 1'b0;
`ifdef CFG_PARITY_EN
      frame_err_q <= 1'b0;
`endif
      unique case (state_q)
        StHunt: begin
          if (hunt_shift) begin
            if (match) begin
              state_q   <= StLoad;
              fill_q    <= '0;
              bit_cnt_q <= '0;
            end else begin
              fill_q <= fill_inc;
            end
          end
        end
        StLoad: begin
          if (load_shift) begin
            if (bit_cnt_q == LastBit) begin
`ifdef CFG_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StCheck;
`endif
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        StParity: begin
`ifdef CFG_PARITY_EN
          if (en) begin
            // Even parity: payload ones plus the parity bit must be even.
            parity_ok_q <= ~(^shadow_q ^ in);
            state_q     <= StCheck;
          end
`else
          state_q <= StHunt;
`endif
        end
        StCheck: begin
          if (frame_ok) begin
            out_sel    <= shadow_q[FRAME_W-1];
            clk_sel    <= shadow_q[FRAME_W-2];
            out1       <= jump_field(shadow_q, 0);
            out2       <= jump_field(shadow_q, 1);
            out3       <= jump_field(shadow_q, 2);
            out4       <= jump_field(shadow_q, 3);
            out5       <= jump_field(shadow_q, 4);
            load_pulse <= 1'b1;
            finished   <= 1'b1;
          end
`ifdef CFG_PARITY_EN
          else begin
            frame_err_q <= 1'b1;
          end
`endif
          state_q <= StHunt;
          fill_q  <= '0;
        end
      endcase
    end
  end

endmodule
